// File: rtl/adc_trigbuf_if.sv
// Stream port of the ADC trigger buffer.
// The master drives the event words and the slave returns DREADY.
interface adc_trigbuf_if;
    logic [15:0] DOUT;
    logic        DVALID;
    logic        DLAST;
    logic        DREADY;

    modport master (
        output DOUT,
        output DVALID,
        output DLAST,
        input  DREADY
    );

    modport slave (
        input  DOUT,
        input  DVALID,
        input  DLAST,
        output DREADY
    );
endinterface

// File: rtl/adc_trigbuf.sv
// Per-channel self-triggered capture buffer with circular history.
// Freezes a pre/post trigger window and streams it with a TS header.
module adc_trigbuf #(
    parameter int ABITS = 9
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [11:0]      DIN,
    input  logic             ENB,
    input  logic [11:0]      THR,
    input  logic [7:0]       PRE,
    input  logic [ABITS-1:0] WIN,
    input  logic             TRGEXT,
    adc_trigbuf_if.master    dst,
    output logic             BUSY,
    output logic [15:0]      MISS
);

    typedef enum logic [1:0] {FILL, ARMED, POST, READ} state_t;

    localparam int DEPTH = 1 << ABITS;
    localparam int PW    = (ABITS > 8) ? ABITS : 8;

    state_t           state, state_n;
    logic [11:0]      ring [DEPTH];
    logic [11:0]      rdata;
    logic [11:0]      din_prev;
    logic [11:0]      ts, ts_h, hdr_ts;
    logic [ABITS-1:0] wptr, rptr, ra;
    logic [ABITS-1:0] start, w, post, left;
    logic [ABITS-1:0] p_n, start_n, post_n, hdr_w;
    logic [PW-1:0]    pre_x, win_x;
    logic [8:0]       fill_cnt;
    logic             trg, we, arm_trg, go_read;
    logic             load, done, enter;

    assign trg     = TRGEXT | ((DIN > THR) & (din_prev <= THR));
    assign we      = (state != READ);
    assign pre_x   = PW'(PRE);
    assign win_x   = PW'(WIN);
    assign start_n = wptr - p_n;
    assign post_n  = WIN - p_n - ABITS'(1);
    assign go_read = (WIN == '0) || (post_n == '0);
    assign arm_trg = (state == ARMED) & trg & ENB;
    assign load    = (state == READ) & dst.DVALID & dst.DREADY & ~dst.DLAST;
    assign done    = (state == READ) & dst.DVALID & dst.DREADY & dst.DLAST;
    assign enter   = (state_n == READ) && (state != READ);
    assign hdr_ts  = (state == ARMED) ? ts : ts_h;
    assign hdr_w   = (state == ARMED) ? WIN : w;
    assign BUSY    = (state != ARMED);

    // Pre-trigger depth, clamped so the trigger sample stays inside the window
    always_comb begin
        p_n = '0;
        if (WIN != '0) begin
            if (pre_x >= win_x) p_n = ABITS'(win_x - PW'(1));
            else                p_n = ABITS'(pre_x);
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            FILL:  if ((fill_cnt >= {1'b0, PRE}) && ENB) state_n = ARMED;
            ARMED: if (arm_trg) state_n = go_read ? READ : POST;
            POST:  if (post == ABITS'(1)) state_n = READ;
            READ:  if (done) state_n = FILL;
            default: state_n = FILL;
        endcase
    end

    // Read address: park on the window start until READ, then advance per load
    always_comb begin
        ra = rptr;
        if (state == ARMED)     ra = start_n;
        else if (state == POST) ra = start;
        else if (load)          ra = rptr + ABITS'(1);
    end

    // Ring write and prefetch read, with write-first bypass on collision
    always_ff @(posedge CLK) begin
        if (we) ring[wptr] <= DIN;
        rdata <= (we && (ra == wptr)) ? DIN : ring[ra];
    end

    // Control state, pointers, timestamp and miss counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= FILL;
            ts       <= '0;
            ts_h     <= '0;
            din_prev <= '0;
            wptr     <= '0;
            rptr     <= '0;
            start    <= '0;
            w        <= '0;
            post     <= '0;
            fill_cnt <= '0;
            MISS     <= '0;
        end else begin
            state    <= state_n;
            ts       <= ts + 12'd1;
            din_prev <= DIN;
            rptr     <= ra;
            if (we) wptr <= wptr + ABITS'(1);
            if (trg && (state != ARMED) && (MISS != 16'hFFFF))
                MISS <= MISS + 16'd1;
            if ((state == FILL) && (fill_cnt != 9'h1FF))
                fill_cnt <= fill_cnt + 9'd1;
            if (done) fill_cnt <= '0;
            if (arm_trg) begin
                w     <= WIN;
                ts_h  <= ts;
                start <= start_n;
                post  <= post_n;
            end
            if (state == POST) post <= post - ABITS'(1);
        end
    end

    // Output stream register: header on entry, then one sample per acceptance
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dst.DOUT   <= '0;
            dst.DVALID <= 1'b0;
            dst.DLAST  <= 1'b0;
            left       <= '0;
        end else if (enter) begin
            dst.DOUT   <= {1'b1, 3'b000, hdr_ts};
            dst.DVALID <= 1'b1;
            dst.DLAST  <= (hdr_w == '0);
            left       <= hdr_w;
        end else if (load) begin
            dst.DOUT  <= {4'b0000, rdata};
            dst.DLAST <= (left == ABITS'(1));
            left      <= left - ABITS'(1);
        end else if (done) begin
            dst.DOUT   <= '0;
            dst.DVALID <= 1'b0;
            dst.DLAST  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adc_trigbuf.sv
// Randomized bench for adc_trigbuf against a queue-based event model.
// The model keeps the written sample history and builds each event's words.
module tb_adc_trigbuf;
    localparam int ABITS = 9;

    typedef enum int {M_FILL, M_ARMED, M_POST, M_READ} mode_t;

    logic             CLK = 1'b0;
    logic             RST_N = 1'b0;
    logic [11:0]      DIN = '0;
    logic             ENB = 1'b0;
    logic [11:0]      THR = '0;
    logic [7:0]       PRE = '0;
    logic [ABITS-1:0] WIN = '0;
    logic             TRGEXT = 1'b0;
    logic             BUSY;
    logic [15:0]      MISS;

    adc_trigbuf_if bus ();

    adc_trigbuf #(.ABITS(ABITS)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .DIN    (DIN),
        .ENB    (ENB),
        .THR    (THR),
        .PRE    (PRE),
        .WIN    (WIN),
        .TRGEXT (TRGEXT),
        .dst    (bus),
        .BUSY   (BUSY),
        .MISS   (MISS)
    );

    always #4 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int n_enb, n_thr, n_pre, n_win;

    mode_t       mode;
    int          cnt, miss, ts, prev, post, ecnt, ts_h, rd_cyc;
    int          hist[$];
    int          win_q[$];
    int          exp_q[$];
    bit          hdr_wait;
    int          t_trig, lat;
    bit          prev_stall;
    logic [15:0] prev_dout;
    logic        prev_last;
    bit          abort;
    int          events;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mode = M_FILL;
        cnt = 0; miss = 0; ts = 0; prev = 0; post = 0; rd_cyc = 0;
        hist = {}; win_q = {}; exp_q = {};
        hdr_wait = 0; prev_stall = 0;
    endtask

    task automatic push_hist(input int v);
        hist.push_back(v);
        if (hist.size() > 1024) void'(hist.pop_front());
    endtask

    task automatic add_miss();
        if (miss < 65535) miss++;
    endtask

    task automatic enter_read();
        exp_q = {};
        exp_q.push_back(32768 + ts_h);
        foreach (win_q[i]) exp_q.push_back(win_q[i]);
        mode = M_READ;
        rd_cyc = 0;
        events++;
    endtask

    // Drive inputs for the coming edge, score accepted words, advance the model
    task automatic drive_model(input logic [11:0] d, input logic t, input logic r);
        bit acc, last_acc, trg;
        int e, wl, p;
        DIN = d; TRGEXT = t; bus.DREADY = r;
        ENB = n_enb[0]; THR = n_thr[11:0];
        PRE = n_pre[7:0]; WIN = n_win[ABITS-1:0];
        acc = bus.DVALID & bus.DREADY;
        last_acc = 0;
        if (acc) begin
            chk("q_has", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e >= 0) chk("word", bus.DOUT, e);
                chk("last", bus.DLAST, exp_q.size() == 0);
                last_acc = (exp_q.size() == 0);
            end
        end
        prev_stall = bus.DVALID & ~bus.DREADY;
        prev_dout = bus.DOUT;
        prev_last = bus.DLAST;
        trg = t | ((int'(d) > n_thr) && (prev <= n_thr));
        ecnt++;
        case (mode)
            M_FILL: begin
                push_hist(d);
                if (trg) add_miss();
                if (cnt >= n_pre && n_enb != 0) mode = M_ARMED;
                if (cnt < 511) cnt++;
            end
            M_ARMED: begin
                if (trg && n_enb != 0) begin
                    wl = n_win;
                    p = (wl == 0) ? 0 : ((n_pre >= wl) ? wl - 1 : n_pre);
                    win_q = {};
                    for (int i = p; i >= 1; i--)
                        win_q.push_back(hist.size() >= i ? hist[hist.size() - i] : -1);
                    if (wl > 0) win_q.push_back(d);
                    ts_h = ts;
                    post = wl - p - 1;
                    t_trig = ecnt;
                    lat = wl - p;
                    hdr_wait = 1;
                    if (post <= 0) enter_read();
                    else mode = M_POST;
                end
                push_hist(d);
            end
            M_POST: begin
                push_hist(d);
                win_q.push_back(d);
                if (trg) add_miss();
                post--;
                if (post == 0) enter_read();
            end
            default: begin
                if (trg) add_miss();
                rd_cyc++;
                if (last_acc) begin
                    mode = M_FILL;
                    cnt = 0;
                end
            end
        endcase
        prev = d;
        ts = (ts + 1) % 4096;
    endtask

    // Checks on the state the DUT settled into after the last edge
    task automatic observe();
        chk("busy", BUSY, mode != M_ARMED);
        chk("miss", MISS, miss);
        if (prev_stall) begin
            chk("hold_v", bus.DVALID, 1);
            chk("hold_d", bus.DOUT, prev_dout);
            chk("hold_l", bus.DLAST, prev_last);
        end
        if (mode != M_READ) chk("idle_v", bus.DVALID, 0);
        if (hdr_wait) begin
            if (bus.DVALID) begin
                hdr_wait = 0;
                chk("hdr_lat", (ecnt - t_trig) <= lat + 3, 1);
            end else if (ecnt - t_trig >= lat + 3) begin
                hdr_wait = 0;
                chk("hdr_due", bus.DVALID, 1);
            end
        end
        if (mode == M_READ && rd_cyc > 2000) begin
            chk("rd_timeout", rd_cyc <= 2000, 1);
            abort = 1;
            mode = M_FILL;
            exp_q = {};
        end
    endtask

    task automatic cycle(input logic [11:0] d, input logic t, input logic r);
        if (abort) return;
        @(negedge CLK);
        observe();
        drive_model(d, t, r);
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_reset();
        repeat (3) @(negedge CLK);
        chk("rst_dout", bus.DOUT, 0);
        chk("rst_v", bus.DVALID, 0);
        chk("rst_l", bus.DLAST, 0);
        chk("rst_busy", BUSY, 1);
        chk("rst_miss", MISS, 0);
        RST_N = 1'b1;
        drive_model(12'd0, 1'b0, 1'b1);
    endtask

    initial begin
        int n;
        abort = 0; events = 0; ecnt = 0;
        bus.DREADY = 1'b0;

        // Ramp through threshold, free-flowing consumer
        n_enb = 1; n_thr = 100; n_pre = 4; n_win = 16;
        do_reset();
        for (int i = 0; i < 200; i++) cycle(12'(i), 1'b0, 1'b1);
        chk("ramp_ev", events, 1);

        // Same ramp with a consumer ready one cycle in three
        do_reset();
        for (int i = 0; i < 250; i++) cycle(12'(i), 1'b0, (i % 3) == 0);
        chk("stall_ev", events, 2);

        // External trigger every 5 cycles, long window, ring wraps
        n_thr = 4095; n_pre = 8; n_win = 64;
        do_reset();
        for (int i = 0; i < 1500; i++)
            cycle(12'($urandom), (i % 5) == 0, $urandom_range(0, 3) != 0);

        // Header-only events, then PRE clamped to WIN-1
        n_pre = 3; n_win = 0;
        do_reset();
        for (int i = 0; i < 100; i++) cycle(12'($urandom), (i % 9) == 0, 1'b1);
        n_pre = 10; n_win = 4;
        for (int i = 0; i < 100; i++) cycle(12'($urandom), (i % 9) == 0, $urandom_range(0, 1) == 1);

        // Random thresholds, windows, enables and back-pressure
        do_reset();
        for (int i = 0; i < 4500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                n_thr = 1948 + $urandom_range(0, 200);
                n_pre = $urandom_range(0, 60);
                n_win = $urandom_range(0, 50);
            end
            n_enb = ($urandom_range(0, 15) != 0);
            cycle(12'(1848 + $urandom_range(0, 400)),
                  $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) != 0);
        end

        // Reset asserted while an event is being streamed
        n_enb = 1; n_thr = 4095; n_pre = 5; n_win = 20;
        do_reset();
        n = 0;
        while (!bus.DVALID && n < 500 && !abort) begin
            cycle(12'($urandom), (n % 7) == 0, 1'b0);
            n++;
        end
        chk("mid_rd_seen", bus.DVALID, 1);
        #2 RST_N = 1'b0;
        #1;
        chk("abort_v", bus.DVALID, 0);
        chk("abort_busy", BUSY, 1);
        do_reset();
        for (int i = 0; i < 300; i++)
            cycle(12'($urandom), $urandom_range(0, 19) == 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
